// File: rtl/pcie_tlp_axi_wr_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pcie_tlp_axi_wr_master
//
// Inbound write path of the PCIe bridge. Takes one decoded Memory-Write TLP
// (header fields, target address, up to MAX_DW dwords of payload) and replays
// it on AXI4 as a single INCR write burst of 16-byte beats. After the burst
// it waits for the B response and reports the outcome as a one-cycle pulse.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   tlp_valid_i / tlp_ready_o     TLP handshake (ready only while idle)
//   header_fmt_i, header_type_i   TLP fmt/type; only MWr 3DW/4DW is accepted
//   header_length_i               payload length in dwords (1..MAX_DW)
//   addr_i                        target byte address, must be 16-byte aligned
//   data_i                        payload, DW0 in bits [31:0]
//   aw*                           AXI write-address channel (master side)
//   w*                            AXI write-data channel (master side)
//   bid, bresp, bvalid / bready   AXI write-response channel
//   wr_done_o                     pulse: burst finished with OKAY and our ID
//   err_o, err_code_o             pulse + code: 1 unsupported TLP,
//                                 2 misaligned address, 3 bad B response
// -----------------------------------------------------------------------------
module pcie_tlp_axi_wr_master #(
  parameter int          ID_WIDTH   = 4,
  parameter int unsigned AXI_ID     = 0,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 128,
  parameter int          MAX_DW     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  // TLP side
  input  logic                     tlp_valid_i,
  output logic                     tlp_ready_o,
  input  logic [2:0]               header_fmt_i,
  input  logic [4:0]               header_type_i,
  input  logic [8:0]               header_length_i,
  input  logic [ADDR_WIDTH-1:0]    addr_i,
  input  logic [MAX_DW*32-1:0]     data_i,
  // AXI write address
  output logic [ID_WIDTH-1:0]      awid,
  output logic [ADDR_WIDTH-1:0]    awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic                     awvalid,
  input  logic                     awready,
  // AXI write data
  output logic [ID_WIDTH-1:0]      wid,
  output logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH/8-1:0]  wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  // AXI write response
  input  logic [ID_WIDTH-1:0]      bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  // Status
  output logic                     wr_done_o,
  output logic                     err_o,
  output logic [1:0]               err_code_o
);

  localparam int PAYLOAD_W = MAX_DW * 32;
  localparam int BEATS     = PAYLOAD_W / DATA_WIDTH;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int STRB_W    = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_BURST = 2'b01;
  localparam logic [1:0] ST_RESP  = 2'b10;

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_UNSUP = 2'd1;
  localparam logic [1:0] CODE_ALIGN = 2'd2;
  localparam logic [1:0] CODE_BRESP = 2'd3;

  logic [1:0]            state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [8:0]            len_reg;
  logic [PAYLOAD_W-1:0]  data_reg;
  logic                  awvalid_reg;
  logic                  wvalid_reg;
  logic                  aw_done_reg;
  logic                  w_done_reg;
  logic [7:0]            beat_reg;
  logic                  wr_done_reg;
  logic                  err_reg;
  logic [1:0]            err_code_reg;

  // ---------------------------------------------------------------------------
  // TLP acceptance and header checks
  // ---------------------------------------------------------------------------
  logic       accept;
  logic       fmt_ok;
  logic       type_ok;
  logic       len_ok;
  logic       addr_ok;
  logic [1:0] check_code;

  assign tlp_ready_o = (state_reg == ST_IDLE) & ~rst;
  assign accept      = tlp_valid_i & tlp_ready_o;

  assign fmt_ok  = (header_fmt_i == 3'b010) || (header_fmt_i == 3'b011);
  assign type_ok = (header_type_i == 5'b00000);
  assign len_ok  = (header_length_i != 9'd0) && (header_length_i <= 9'(MAX_DW));
  // Bursts always start on a beat boundary; the low address bits index bytes
  // within one 16-byte beat.
  assign addr_ok = (addr_i[3:0] == 4'h0);

  // An unsupported TLP is reported ahead of a misaligned address.
  always_comb begin
    check_code = CODE_NONE;
    if (!(fmt_ok && type_ok && len_ok)) begin
      check_code = CODE_UNSUP;
    end else if (!addr_ok) begin
      check_code = CODE_ALIGN;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst geometry and beat selection
  // ---------------------------------------------------------------------------
  logic [9:0]            len_plus3;
  logic [7:0]            awlen_w;
  logic                  last_beat;
  logic [DATA_WIDTH-1:0] beat_data [BEATS];
  logic [STRB_W-1:0]     last_strb;

  // Number of beats is ceil(length/4); AXI encodes it as beats-1.
  assign len_plus3 = {1'b0, len_reg} + 10'd3;
  assign awlen_w   = len_plus3[9:2] - 8'd1;
  assign last_beat = (beat_reg == awlen_w);

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign beat_data[gi] = data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
    // Byte lane gi belongs to dword gi/4 of the beat. On the final beat only
    // the first length%4 dwords carry payload (all four when the remainder
    // is zero).
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
      assign last_strb[gi] = (len_reg[1:0] == 2'd0) || (2'(gi / 4) < len_reg[1:0]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // AXI outputs
  // ---------------------------------------------------------------------------
  assign awid    = ID_WIDTH'(AXI_ID);
  assign awaddr  = addr_reg;
  assign awlen   = awlen_w;
  assign awsize  = 3'b100;
  assign awburst = 2'b01;
  assign awvalid = awvalid_reg;

  assign wid    = ID_WIDTH'(AXI_ID);
  assign wdata  = beat_data[beat_reg[BEAT_W-1:0]];
  assign wstrb  = last_beat ? last_strb : {STRB_W{1'b1}};
  assign wlast  = last_beat;
  assign wvalid = wvalid_reg;

  assign bready = (state_reg == ST_RESP);

  assign wr_done_o  = wr_done_reg;
  assign err_o      = err_reg;
  assign err_code_o = err_code_reg;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;
  logic b_ok;

  assign aw_hs = awvalid_reg & awready;
  assign w_hs  = wvalid_reg & wready;
  // AW and W complete independently; each side is finished once its own
  // handshake has happened, either in an earlier cycle or in this one.
  assign aw_fin = aw_done_reg | aw_hs;
  assign w_fin  = w_done_reg | (w_hs & last_beat);
  assign b_ok   = (bresp == 2'b00) && (bid == ID_WIDTH'(AXI_ID));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      awvalid_reg  <= 1'b0;
      wvalid_reg   <= 1'b0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
      beat_reg     <= 8'd0;
      wr_done_reg  <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= CODE_NONE;
      addr_reg     <= '0;
      len_reg      <= 9'd0;
      data_reg     <= '0;
    end else begin
      wr_done_reg <= 1'b0;
      err_reg     <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            addr_reg <= addr_i;
            len_reg  <= header_length_i;
            data_reg <= data_i;
            if (check_code != CODE_NONE) begin
              // Rejected TLPs are consumed without any AXI traffic.
              err_reg      <= 1'b1;
              err_code_reg <= check_code;
            end else begin
              state_reg   <= ST_BURST;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              aw_done_reg <= 1'b0;
              w_done_reg  <= 1'b0;
              beat_reg    <= 8'd0;
            end
          end
        end

        ST_BURST: begin
          if (aw_hs) begin
            awvalid_reg <= 1'b0;
            aw_done_reg <= 1'b1;
          end
          if (w_hs) begin
            if (last_beat) begin
              wvalid_reg <= 1'b0;
              w_done_reg <= 1'b1;
            end else begin
              beat_reg <= beat_reg + 8'd1;
            end
          end
          if (aw_fin && w_fin) begin
            state_reg <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (bvalid) begin
            if (b_ok) begin
              wr_done_reg <= 1'b1;
            end else begin
              err_reg      <= 1'b1;
              err_code_reg <= CODE_BRESP;
            end
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
